// File: rtl/acc_pkg.sv
// Shared types for the accelerator memory interface: word, address and
// posted-write buffer entry.
package acc_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } wbuf_entry_t;

endpackage

// File: rtl/mem_resp_wbuf.sv
// Posted-write FIFO. Besides push/pop it offers a combinational lookup that
// returns the data of the youngest buffered entry whose array index matches.
module mem_resp_wbuf
    import acc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  wbuf_entry_t              push_entry_i,
    input  logic                     pop_i,
    output wbuf_entry_t              head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    input  logic [IDX_W-1:0]         lookup_idx_i,
    output logic                     lookup_hit_o,
    output data_t                    lookup_data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wbuf_entry_t        buf_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = buf_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Entry storage; contents need no reset because count guards validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            buf_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Per-age match vector: age 0 is the oldest entry (head), higher ages are younger.
    logic [DEPTH-1:0] age_match;
    data_t            age_data [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PTR_W-1:0] slot;
        assign slot           = rd_ptr_q + PTR_W'(gi);
        assign age_match[gi]  = ((PTR_W+1)'(gi) < count_q) &&
                                (buf_q[slot].addr[IDX_W-1:0] == lookup_idx_i);
        assign age_data[gi]   = buf_q[slot].data;
    end

    // Scan oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_match[k]) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = age_data[k];
            end
        end
    end

endmodule

// File: rtl/mem_resp.sv
// Memory-side responder: single-port word array fronted by a posted-write
// buffer. Reads always win the array port; the buffer drains on read-free
// cycles. Read data comes back a fixed READ_LAT cycles after acceptance.
module mem_resp
    import acc_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int WBUF_DEPTH = 4,
    parameter int READ_LAT   = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  mem_rden_i,
    input  addr_t mem_raddr_i,
    output data_t mem_rdata_o,
    output logic  mem_rvalid_o,
    input  logic  mem_wren_i,
    input  addr_t mem_waddr_i,
    input  data_t mem_wdata_i,
    output logic  mem_wready_o
);

    localparam int IDX_W = $clog2(DEPTH);

    data_t                         mem_q [DEPTH];
    data_t                         arr_rdata_q;
    logic                          v1_q;
    logic                          hit1_q;
    data_t                         fwd1_q;
    data_t                         sel1;

    wbuf_entry_t                   wbuf_head;
    wbuf_entry_t                   wbuf_push_entry;
    logic [$clog2(WBUF_DEPTH):0]   wbuf_count;
    logic                          wbuf_full;
    logic                          wbuf_empty;
    logic                          fwd_hit;
    data_t                         fwd_data;

    logic                          wr_accept;
    logic                          rd_accept;
    logic                          drain;
    logic [IDX_W-1:0]              rd_idx;
    logic [IDX_W-1:0]              drain_idx;

    // Reads have the port; a drain only happens on a cycle with no read.
    assign mem_wready_o = !rst_i && !wbuf_full;
    assign wr_accept    = mem_wren_i && mem_wready_o;
    assign rd_accept    = mem_rden_i && !rst_i;
    assign drain        = !mem_rden_i && !wbuf_empty && !rst_i;
    assign rd_idx       = mem_raddr_i[IDX_W-1:0];
    assign drain_idx    = wbuf_head.addr[IDX_W-1:0];

    assign wbuf_push_entry.addr = mem_waddr_i;
    assign wbuf_push_entry.data = mem_wdata_i;

    // Address bits above the array index alias by design.
    logic unused_ok;
    assign unused_ok = ^{mem_raddr_i[ADDR_W-1:IDX_W], wbuf_head.addr[ADDR_W-1:IDX_W], wbuf_count};

    mem_resp_wbuf #(
        .DEPTH (WBUF_DEPTH),
        .IDX_W (IDX_W)
    ) u_wbuf (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (wr_accept),
        .push_entry_i  (wbuf_push_entry),
        .pop_i         (drain),
        .head_o        (wbuf_head),
        .count_o       (wbuf_count),
        .full_o        (wbuf_full),
        .empty_o       (wbuf_empty),
        .lookup_idx_i  (rd_idx),
        .lookup_hit_o  (fwd_hit),
        .lookup_data_o (fwd_data)
    );

    // Single-port array: registered read on a read cycle, otherwise drain write.
    always_ff @(posedge clk_i) begin
        if (rd_accept) begin
            arr_rdata_q <= mem_q[rd_idx];
        end else if (drain) begin
            mem_q[drain_idx] <= wbuf_head.data;
        end
    end

    // First read stage: capture the forwarding result alongside the array read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q   <= 1'b0;
            hit1_q <= 1'b0;
            fwd1_q <= '0;
        end else begin
            v1_q <= rd_accept;
            if (rd_accept) begin
                hit1_q <= fwd_hit;
                fwd1_q <= fwd_data;
            end
        end
    end

    assign sel1 = hit1_q ? fwd1_q : arr_rdata_q;

    if (READ_LAT == 1) begin : g_lat1
        logic seen_q;

        // Masks the unreset array register until a read has been issued.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                seen_q <= 1'b0;
            end else if (rd_accept) begin
                seen_q <= 1'b1;
            end
        end

        assign mem_rvalid_o = v1_q;
        assign mem_rdata_o  = seen_q ? sel1 : '0;
    end else begin : g_latn
        logic [READ_LAT:2] v_q;
        data_t             d_q [READ_LAT:2];

        // Delay line; each stage's data only moves with a valid so the output holds.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v_q <= '0;
                for (int k = 2; k <= READ_LAT; k++) begin
                    d_q[k] <= '0;
                end
            end else begin
                v_q[2] <= v1_q;
                if (v1_q) d_q[2] <= sel1;
                for (int k = 3; k <= READ_LAT; k++) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) d_q[k] <= d_q[k-1];
                end
            end
        end

        assign mem_rvalid_o = v_q[READ_LAT];
        assign mem_rdata_o  = d_q[READ_LAT];
    end

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp with default parameters (READ_LAT = 2).
module tb_mem_resp;
    import acc_pkg::*;

    logic  clk_i = 1'b0;
    logic  rst_i;
    logic  mem_rden_i;
    addr_t mem_raddr_i;
    data_t mem_rdata_o;
    logic  mem_rvalid_o;
    logic  mem_wren_i;
    addr_t mem_waddr_i;
    data_t mem_wdata_i;
    logic  mem_wready_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_resp dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_rden_i   (mem_rden_i),
        .mem_raddr_i  (mem_raddr_i),
        .mem_rdata_o  (mem_rdata_o),
        .mem_rvalid_o (mem_rvalid_o),
        .mem_wren_i   (mem_wren_i),
        .mem_waddr_i  (mem_waddr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_wready_o (mem_wready_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr1(input logic [31:0] addr, input logic [31:0] data);
        mem_wren_i  = 1'b1;
        mem_waddr_i = addr;
        mem_wdata_i = data;
        tick();
        mem_wren_i  = 1'b0;
        $display("write addr=0x%08h data=0x%08h", addr, data);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        mem_rden_i  = 1'b1;
        mem_raddr_i = addr;
        tick();
        mem_rden_i  = 1'b0;
        check({tag, "_early"}, 32'(mem_rvalid_o), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(mem_rvalid_o), 32'd1);
        check({tag, "_data"}, mem_rdata_o, exp);
        $display("read  addr=0x%08h data=0x%08h valid=%0d (%s)", addr, mem_rdata_o, mem_rvalid_o, tag);
    endtask

    initial begin
        rst_i       = 1'b1;
        mem_rden_i  = 1'b0;
        mem_raddr_i = '0;
        mem_wren_i  = 1'b0;
        mem_waddr_i = '0;
        mem_wdata_i = '0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rvalid", 32'(mem_rvalid_o), 32'd0);
            check("rst_rdata", mem_rdata_o, 32'd0);
            check("rst_wready", 32'(mem_wready_o), 32'd0);
        end
        rst_i = 1'b0;
        #1;
        check("post_rst_wready", 32'(mem_wready_o), 32'd1);

        // Plain write, let it drain, read back from the array.
        wr1(32'h10, 32'hDEADBEEF);
        idle(5);
        rd_check("basic", 32'h10, 32'hDEADBEEF);
        tick();
        check("hold_rvalid", 32'(mem_rvalid_o), 32'd0);
        check("hold_rdata", mem_rdata_o, 32'hDEADBEEF);

        // Two writes to one address still buffered; youngest must be forwarded.
        mem_wren_i = 1'b1; mem_waddr_i = 32'h20; mem_wdata_i = 32'h11111111;
        tick();
        mem_wdata_i = 32'h22222222;
        tick();
        mem_wren_i = 1'b0;
        mem_rden_i = 1'b1; mem_raddr_i = 32'h20;
        tick();
        mem_rden_i = 1'b0;
        check("fwd_early", 32'(mem_rvalid_o), 32'd0);
        tick();
        check("fwd_valid", 32'(mem_rvalid_o), 32'd1);
        check("fwd_data", mem_rdata_o, 32'h22222222);
        $display("read  addr=0x00000020 data=0x%08h (forwarded)", mem_rdata_o);
        idle(4);
        rd_check("fwd_drained", 32'h20, 32'h22222222);

        // Same-cycle write and read: the read sees old data, the next read the new.
        wr1(32'h30, 32'hA5A5A5A5);
        idle(3);
        mem_wren_i = 1'b1; mem_waddr_i = 32'h30; mem_wdata_i = 32'h5A5A5A5A;
        mem_rden_i = 1'b1; mem_raddr_i = 32'h30;
        tick();
        mem_wren_i = 1'b0;
        tick();
        mem_rden_i = 1'b0;
        check("haz_old_valid", 32'(mem_rvalid_o), 32'd1);
        check("haz_old_data", mem_rdata_o, 32'hA5A5A5A5);
        $display("read  addr=0x00000030 data=0x%08h (same-cycle)", mem_rdata_o);
        tick();
        check("haz_new_valid", 32'(mem_rvalid_o), 32'd1);
        check("haz_new_data", mem_rdata_o, 32'h5A5A5A5A);
        $display("read  addr=0x00000030 data=0x%08h (next-cycle)", mem_rdata_o);

        // Sustained reads starve the drain: four writes fit, the fifth waits.
        idle(6);
        mem_rden_i = 1'b1; mem_raddr_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            mem_wren_i  = 1'b1;
            mem_waddr_i = 32'h40 + 32'(i);
            mem_wdata_i = 32'h1000 + 32'(i);
            check($sformatf("bp_wready%0d", i), 32'(mem_wready_o), (i < 4) ? 32'd1 : 32'd0);
            tick();
            $display("write offer addr=0x%08h wready_after=%0d", mem_waddr_i, mem_wready_o);
        end
        check("bp_stall", 32'(mem_wready_o), 32'd0);
        mem_rden_i = 1'b0;
        tick();
        check("bp_drain_wready", 32'(mem_wready_o), 32'd1);
        mem_rden_i = 1'b1;
        tick();
        check("bp_fifth_taken", 32'(mem_wready_o), 32'd0);
        mem_wren_i = 1'b0;
        mem_rden_i = 1'b0;
        idle(6);
        rd_check("bp_fifth", 32'h44, 32'h1004);
        rd_check("bp_first", 32'h40, 32'h1000);

        // Reset with buffered writes and reads in flight.
        wr1(32'h50, 32'hAAAA0000);
        wr1(32'h51, 32'hAAAA0001);
        wr1(32'h52, 32'hAAAA0002);
        idle(5);
        mem_rden_i = 1'b1; mem_raddr_i = 32'h60;
        for (int i = 0; i < 3; i++) begin
            mem_wren_i  = 1'b1;
            mem_waddr_i = 32'h50 + 32'(i);
            mem_wdata_i = 32'hBBBB0000 + 32'(i);
            tick();
        end
        mem_wren_i = 1'b0;
        mem_rden_i = 1'b0;
        rst_i      = 1'b1;
        tick();
        check("mid_rst_rvalid", 32'(mem_rvalid_o), 32'd0);
        check("mid_rst_rdata", mem_rdata_o, 32'd0);
        check("mid_rst_wready", 32'(mem_wready_o), 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
        check("mid_rst_wready_after", 32'(mem_wready_o), 32'd1);
        tick();
        check("mid_rst_no_rvalid1", 32'(mem_rvalid_o), 32'd0);
        tick();
        check("mid_rst_no_rvalid2", 32'(mem_rvalid_o), 32'd0);
        rd_check("lost_50", 32'h50, 32'hAAAA0000);
        rd_check("lost_52", 32'h52, 32'hAAAA0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
